// File: rtl/data_sync_capture_pkg.sv
// data_sync_capture shared types and constants.
// FSM states, enable-mode encodings, settle limit.
package data_sync_capture_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam int EN_MODE_LEVEL  = 0;
  localparam int EN_MODE_TOGGLE = 1;

  localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/data_sync_capture_en_edge_detect.sv
// en_edge_detect: registers SYNC_EN, flags a rising (level) or any (toggle) edge.
// Ports: CLK, RST (async high), SYNC_EN in; en_edge out (combinational).
module en_edge_detect
  import data_sync_capture_pkg::*;
#(
  parameter int EN_MODE = EN_MODE_LEVEL
) (
  input  logic CLK,
  input  logic RST,
  input  logic SYNC_EN,
  output logic en_edge
);

  logic en_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) en_q <= 1'b0;
    else     en_q <= SYNC_EN;
  end

  if (EN_MODE == EN_MODE_TOGGLE) begin : g_tgl
    assign en_edge = SYNC_EN ^ en_q;
  end else begin : g_lvl
    assign en_edge = SYNC_EN & ~en_q;
  end

endmodule

// File: rtl/data_sync_capture.sv
// data_sync_capture: waits SETTLE_CYCLES after an enable edge, then captures
// UNSYNC_BUS into SYNC_BUS with a one-cycle EN_PULSE; OVERRUN flags an edge
// arriving mid-settle. Ports: CLK, RST (async high), SYNC_EN, UNSYNC_BUS in;
// SYNC_BUS, EN_PULSE, OVERRUN out; ACK_TGL out only with DATA_SYNC_ACK_EN.
module data_sync_capture
  import data_sync_capture_pkg::*;
#(
  parameter int BUS_WIDTH     = 8,
  parameter int SETTLE_CYCLES = 0,
  parameter int EN_MODE       = EN_MODE_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SYNC_EN,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 EN_PULSE,
  output logic                 OVERRUN
`ifdef DATA_SYNC_ACK_EN
  ,
  output logic                 ACK_TGL
`endif
);

  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
    $error("data_sync_capture: SETTLE_CYCLES out of range 0..15");
  end
  if (EN_MODE != EN_MODE_LEVEL && EN_MODE != EN_MODE_TOGGLE) begin : g_bad_mode
    $error("data_sync_capture: EN_MODE must be 0 or 1");
  end

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] RELOAD =
    CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam bit ZERO_SETTLE = (SETTLE_CYCLES == 0);

  logic          en_edge;
  state_t        state;
  logic [CW-1:0] cnt;

  en_edge_detect #(
    .EN_MODE (EN_MODE)
  ) u_edge (
    .CLK     (CLK),
    .RST     (RST),
    .SYNC_EN (SYNC_EN),
    .en_edge (en_edge)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      SYNC_BUS <= '0;
      EN_PULSE <= 1'b0;
      OVERRUN  <= 1'b0;
`ifdef DATA_SYNC_ACK_EN
      ACK_TGL  <= 1'b0;
`endif
    end else begin
      EN_PULSE <= 1'b0;
      OVERRUN  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en_edge) begin
            if (ZERO_SETTLE) begin
              SYNC_BUS <= UNSYNC_BUS;
              EN_PULSE <= 1'b1;
`ifdef DATA_SYNC_ACK_EN
              ACK_TGL  <= ~ACK_TGL;
`endif
            end else begin
              state <= SETTLE;
              cnt   <= RELOAD;
            end
          end
        end
        SETTLE: begin
          // A fresh edge restarts the wait so the newest data wins.
          if (en_edge) begin
            OVERRUN <= 1'b1;
            cnt     <= RELOAD;
          end else if (cnt == '0) begin
            SYNC_BUS <= UNSYNC_BUS;
            EN_PULSE <= 1'b1;
            state    <= IDLE;
`ifdef DATA_SYNC_ACK_EN
            ACK_TGL  <= ~ACK_TGL;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sync_capture.sv
// Scoreboard bench for data_sync_capture: two instances
// (A: zero settle, level mode; B: settle 3, toggle mode).
module tb_data_sync_capture;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       ack;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic [7:0] bus_a, bus_b;
  logic [7:0] sync_a, sync_b;
  logic       pulse_a, pulse_b;
  logic       ovr_a, ovr_b;
  logic       ack_a, ack_b;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   qob[$];
  logic mack_a = 1'b0;
  logic mack_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sync_capture #(
    .BUS_WIDTH     (8),
    .SETTLE_CYCLES (0),
    .EN_MODE       (0)
  ) u_a (
    .CLK        (clk),
    .RST        (rst),
    .SYNC_EN    (en_a),
    .UNSYNC_BUS (bus_a),
    .SYNC_BUS   (sync_a),
    .EN_PULSE   (pulse_a),
    .OVERRUN    (ovr_a)
`ifdef DATA_SYNC_ACK_EN
    ,
    .ACK_TGL    (ack_a)
`endif
  );

  data_sync_capture #(
    .BUS_WIDTH     (8),
    .SETTLE_CYCLES (3),
    .EN_MODE       (1)
  ) u_b (
    .CLK        (clk),
    .RST        (rst),
    .SYNC_EN    (en_b),
    .UNSYNC_BUS (bus_b),
    .SYNC_BUS   (sync_b),
    .EN_PULSE   (pulse_b),
    .OVERRUN    (ovr_b)
`ifdef DATA_SYNC_ACK_EN
    ,
    .ACK_TGL    (ack_b)
`endif
  );

`ifndef DATA_SYNC_ACK_EN
  assign ack_a = 1'b0;
  assign ack_b = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    mack_a = ~mack_a;
    qa.push_back('{cyc + 1, d, mack_a});
  endtask

  task automatic push_b(input logic [7:0] d);
    mack_b = ~mack_b;
    qb.push_back('{cyc + 4, d, mack_b});
  endtask

  // Monitor A
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (pulse_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_pulse", 32'(pulse_a), 0);
      end else begin
        e = qa.pop_front();
        chk("a_pulse_cycle", cyc, e.cyc);
        chk("a_sync_bus", 32'(sync_a), 32'(e.data));
`ifdef DATA_SYNC_ACK_EN
        chk("a_ack_tgl", 32'(ack_a), 32'(e.ack));
`endif
      end
    end
    if (ovr_a) chk("a_unexpected_overrun", 32'(ovr_a), 0);
  end

  // Monitor B
  always @(negedge clk) begin : mon_b
    exp_t e;
    int   oc;
    if (pulse_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_pulse", 32'(pulse_b), 0);
      end else begin
        e = qb.pop_front();
        chk("b_pulse_cycle", cyc, e.cyc);
        chk("b_sync_bus", 32'(sync_b), 32'(e.data));
`ifdef DATA_SYNC_ACK_EN
        chk("b_ack_tgl", 32'(ack_b), 32'(e.ack));
`endif
      end
    end
    if (ovr_b) begin
      if (qob.size() == 0) begin
        chk("b_unexpected_overrun", 32'(ovr_b), 0);
      end else begin
        oc = qob.pop_front();
        chk("b_overrun_cycle", cyc, oc);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    bus_a = 8'h00;
    bus_b = 8'h00;
    tick(3);
    chk("rst_sync_a", 32'(sync_a), 0);
    chk("rst_sync_b", 32'(sync_b), 0);
    chk("rst_pulse_a", 32'(pulse_a), 0);
    chk("rst_pulse_b", 32'(pulse_b), 0);
    chk("rst_ack_b", 32'(ack_b), 0);
    rst = 1'b0;
    tick(5);

    // A: zero settle, single rising edge
    bus_a = 8'hA5; en_a = 1'b1; push_a(8'hA5);
    tick(1);
    // Held high 6 cycles with a changing bus: no further capture
    bus_a = 8'hFF;
    tick(5);
    en_a = 1'b0;
    tick(4);
    chk("a_hold_value", 32'(sync_a), 32'h0A5);
    // Rising edges two cycles apart
    bus_a = 8'h5A; en_a = 1'b1; push_a(8'h5A);
    tick(1);
    en_a = 1'b0;
    tick(1);
    bus_a = 8'hC3; en_a = 1'b1; push_a(8'hC3);
    tick(1);
    en_a = 1'b0;
    tick(4);

    // B: settle delay of 3 on a 0->1 toggle
    bus_b = 8'h3C; en_b = 1'b1; push_b(8'h3C);
    tick(8);
    // Toggle 1->0 then 0->1
    bus_b = 8'h11; en_b = 1'b0; push_b(8'h11);
    tick(8);
    bus_b = 8'h22; en_b = 1'b1; push_b(8'h22);
    tick(8);
    chk("b_hold_value", 32'(sync_b), 32'h022);
    // Overrun: second edge two cycles into settle; newest data wins
    bus_b = 8'h44; en_b = 1'b0;
    tick(2);
    bus_b = 8'h55; en_b = 1'b1;
    qob.push_back(cyc + 1);
    push_b(8'h55);
    tick(10);
    // Minimum spacing (settle+1) gives two clean captures
    bus_b = 8'h66; en_b = 1'b0; push_b(8'h66);
    tick(4);
    bus_b = 8'h77; en_b = 1'b1; push_b(8'h77);
    tick(10);

    // Reset one cycle into settle: pending capture dropped
    bus_b = 8'h99; en_b = 1'b0;
    tick(1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_sync_a", 32'(sync_a), 0);
    chk("midrst_sync_b", 32'(sync_b), 0);
    chk("midrst_pulse_b", 32'(pulse_b), 0);
    chk("midrst_ovr_b", 32'(ovr_b), 0);
    chk("midrst_ack_a", 32'(ack_a), 0);
    mack_a = 1'b0;
    mack_b = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(8);
    chk("post_rst_sync_b", 32'(sync_b), 0);

    // Capture after reset
    bus_b = 8'hAB; en_b = 1'b1; push_b(8'hAB);
    tick(8);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qob_drained", qob.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
